// File: rtl/pipe_run_ctrl.sv
// Run/halt/single-step controller producing the global pipeline enable for the
// 5-stage MIPS pipeline, with a single programmable fetch-PC breakpoint.
module pipe_run_ctrl #(
  parameter int unsigned PC_WIDTH   = 6,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [STEP_WIDTH-1:0] cmd_arg,
  input  logic [PC_WIDTH-1:0]   pc_in,
  output logic                  pipe_en,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [1:0]            state_o,
  output logic                  cmd_ack,
  output logic                  cmd_err,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STEP  = 2'b10;
  localparam logic [1:0] ST_BREAK = 2'b11;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  logic [1:0]            state, state_nx;
  logic [STEP_WIDTH-1:0] step_cnt, step_nx;
  logic [PC_WIDTH-1:0]   bp_addr, bp_addr_nx;
  logic                  bp_en, bp_en_nx;
  logic                  skip, skip_nx;
  logic                  bp_hit_nx;
  logic                  pc_eq, hit, stopped, legal;

  assign pc_eq   = (pc_in == bp_addr);
  assign hit     = bp_en & pc_eq & ~skip;
  assign stopped = (state == ST_HALT) | (state == ST_BREAK);

  // Combinational so the breakpoint PC is frozen before it can enter IFID.
  assign pipe_en = ((state == ST_RUN) & ~hit) | (state == ST_STEP);
  assign halted  = stopped;
  assign state_o = state;

  always_comb begin
    legal = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_HALT: legal = 1'b1;
        OP_RUN:  legal = stopped;
        OP_STEP: legal = stopped & (cmd_arg != '0);
        default: legal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    step_nx    = step_cnt;
    bp_addr_nx = bp_addr;
    bp_en_nx   = bp_en;
    skip_nx    = skip;
    bp_hit_nx  = bp_hit;

    // Priority: HALT command, then breakpoint hit, then remaining commands.
    if (cmd_valid && cmd_op == OP_HALT) begin
      state_nx  = ST_HALT;
      step_nx   = '0;
      bp_hit_nx = 1'b0;
    end else if (state == ST_RUN && hit) begin
      state_nx  = ST_BREAK;
      bp_hit_nx = 1'b1;
    end else if (legal && cmd_op == OP_RUN) begin
      state_nx  = ST_RUN;
      bp_hit_nx = 1'b0;
      if (pc_eq) skip_nx = 1'b1;
    end else if (legal && cmd_op == OP_STEP) begin
      state_nx = ST_STEP;
      step_nx  = cmd_arg;
    end else if (state == ST_STEP) begin
      step_nx = step_cnt - STEP_WIDTH'(1);
      if (step_cnt == STEP_WIDTH'(1)) state_nx = ST_HALT;
    end

    // Skip only survives while the fetch PC still sits on the breakpoint.
    if (state == ST_RUN && !pc_eq) skip_nx = 1'b0;

    if (cmd_valid && cmd_op == OP_SET_BP) begin
      bp_addr_nx = cmd_arg[PC_WIDTH-1:0];
      bp_en_nx   = cmd_arg[PC_WIDTH];
      skip_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HALT;
      step_cnt    <= '0;
      bp_addr     <= '0;
      bp_en       <= 1'b0;
      skip        <= 1'b0;
      bp_hit      <= 1'b0;
      cmd_ack     <= 1'b0;
      cmd_err     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_nx;
      bp_addr  <= bp_addr_nx;
      bp_en    <= bp_en_nx;
      skip     <= skip_nx;
      bp_hit   <= bp_hit_nx;
      cmd_ack  <= cmd_valid & legal;
      cmd_err  <= cmd_valid & ~legal;
      if (pipe_en && cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl with a small PC-register model that advances
// on pipe_en and can loop back over a code region.
module tb_pipe_run_ctrl;

  localparam int unsigned PW = 6;
  localparam int unsigned SW = 8;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [SW-1:0] cmd_arg;
  logic [PW-1:0] pc;
  logic          pipe_en, halted, bp_hit, cmd_ack, cmd_err;
  logic [1:0]    state_o;
  logic [CW-1:0] cycle_count;

  logic [PW-1:0] loop_top, loop_base;
  int            total = 0;
  int            bad = 0;
  int            en_cycles;

  pipe_run_ctrl #(.PC_WIDTH(PW), .STEP_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .pc_in(pc), .pipe_en(pipe_en), .halted(halted),
    .bp_hit(bp_hit), .state_o(state_o), .cmd_ack(cmd_ack),
    .cmd_err(cmd_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (pipe_en) pc <= (pc == loop_top) ? loop_base : pc + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [SW-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
    loop_top = 6'd63; loop_base = 6'd0;
    tick();
    rst = 1'b1;

    // Idle after reset
    repeat (10) tick();
    chk("idle_pipe_en", pipe_en, 0);
    chk("idle_halted", halted, 1);
    chk("idle_state", state_o, 2'b00);
    chk("idle_count", cycle_count, 0);
    chk("idle_bp_hit", bp_hit, 0);
    chk("idle_ack_err", {cmd_ack, cmd_err}, 2'b00);

    // RUN, then HALT sampled on the 20th enabled edge
    issue(2'b01, '0);
    chk("run_ack", cmd_ack, 1);
    chk("run_state", state_o, 2'b01);
    chk("run_pipe_en", pipe_en, 1);
    tick();
    chk("run_ack_one_cycle", cmd_ack, 0);
    repeat (18) tick();
    issue(2'b00, '0);
    chk("halt_ack", cmd_ack, 1);
    chk("halt_state", state_o, 2'b00);
    chk("halt_pipe_en", pipe_en, 0);
    chk("halt_count", cycle_count, 20);
    chk("halt_pc", pc, 20);

    // STEP 3 then STEP 0
    do_reset();
    issue(2'b10, 8'd3);
    chk("step_ack", cmd_ack, 1);
    chk("step_state", state_o, 2'b10);
    en_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (pipe_en) en_cycles++;
      tick();
    end
    chk("step_en_cycles", en_cycles, 3);
    chk("step_end_state", state_o, 2'b00);
    chk("step_count", cycle_count, 3);
    chk("step_pc", pc, 3);
    issue(2'b10, 8'd0);
    chk("step0_err", {cmd_ack, cmd_err}, 2'b01);
    chk("step0_pipe_en", pipe_en, 0);
    chk("step0_state", state_o, 2'b00);
    tick();
    chk("step0_err_one_cycle", cmd_err, 0);

    // Breakpoint at 5, RUN from PC 0
    do_reset();
    issue(2'b11, 8'h45);
    chk("setbp_ack", cmd_ack, 1);
    chk("setbp_state", state_o, 2'b00);
    issue(2'b01, '0);
    repeat (4) tick();
    chk("bp_pre_pc", pc, 4);
    chk("bp_pre_en", pipe_en, 1);
    tick();
    chk("bp_freeze_pc", pc, 5);
    chk("bp_freeze_en", pipe_en, 0);
    chk("bp_freeze_state", state_o, 2'b01);
    tick();
    chk("bp_state", state_o, 2'b11);
    chk("bp_hit", bp_hit, 1);
    chk("bp_halted", halted, 1);
    repeat (2) tick();
    chk("bp_pc_held", pc, 5);
    chk("bp_count", cycle_count, 5);

    // Resume past the breakpoint, loop 9 -> 3 and hit again
    loop_top = 6'd9; loop_base = 6'd3;
    issue(2'b01, '0);
    chk("resume_ack", cmd_ack, 1);
    chk("resume_bp_hit_clr", bp_hit, 0);
    chk("resume_en", pipe_en, 1);
    tick();
    chk("resume_pc6", pc, 6);
    chk("resume_state", state_o, 2'b01);
    tick();
    chk("resume_pc7", pc, 7);
    repeat (5) tick();
    chk("rehit_pc", pc, 5);
    chk("rehit_en", pipe_en, 0);
    tick();
    chk("rehit_state", state_o, 2'b11);
    chk("rehit_bp_hit", bp_hit, 1);
    chk("rehit_count", cycle_count, 12);

    // Illegal STEP in RUN, then HALT colliding with a hit
    issue(2'b01, '0);
    issue(2'b10, 8'd2);
    chk("step_in_run_err", {cmd_ack, cmd_err}, 2'b01);
    chk("step_in_run_state", state_o, 2'b01);
    chk("step_in_run_pc", pc, 6);
    repeat (6) tick();
    chk("collide_pc", pc, 5);
    chk("collide_en", pipe_en, 0);
    issue(2'b00, '0);
    chk("collide_state", state_o, 2'b00);
    chk("collide_bp_hit", bp_hit, 0);
    chk("collide_ack", cmd_ack, 1);

    // Asynchronous reset in the middle of STEP 100
    do_reset();
    loop_top = 6'd63; loop_base = 6'd0;
    issue(2'b10, 8'd100);
    repeat (9) tick();
    chk("mid_step_en", pipe_en, 1);
    chk("mid_step_count", cycle_count, 9);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_en", pipe_en, 0);
    chk("async_rst_state", state_o, 2'b00);
    chk("async_rst_count", cycle_count, 0);
    chk("async_rst_halted", halted, 1);
    tick();
    rst = 1'b1;

    // Counter saturation at all-ones
    issue(2'b01, '0);
    repeat (40) tick();
    chk("sat_running", cycle_count, 31);
    issue(2'b00, '0);
    chk("sat_after_halt", cycle_count, 31);
    chk("sat_state", state_o, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
